// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and default bit period.
// UART_RX_PARITY_EN adds the PARITY state to the receiver state set.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS       = 8;
    // 100 MHz system clock at 115200 baud; also used by the transmitter.
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StBreak
    } uart_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single- or multi-bit level inputs.
// Reset value is a parameter so idle-high lines (UART rx) come out of reset idle.
module sync_2ff #(
    parameter int unsigned       WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, LSB first, one stop bit, mid-bit sampling, one-byte holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit between bit 7 and the stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_parity_err,
    output logic       o_busy
);

    localparam int unsigned     CNT_W     = $clog2(CLKS_PER_BIT);
    // Counter expires at zero, so a period of N cycles loads N-1.
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);

    logic                      rx_s;
    uart_rx_state_t            state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [2:0]                idx_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic [UART_DATA_BITS-1:0] data_q;
    logic                      valid_q;
    logic                      frame_err_q;
    logic                      overrun_q;
    logic                      cnt_done;

    sync_2ff #(
        .WIDTH       (1),
        .RESET_VALUE (1'b1)
    ) u_rx_sync (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_d       (i_rx),
        .o_q       (rx_s)
    );

    assign cnt_done = (cnt_q == '0);

`ifdef UART_RX_PARITY_EN
    logic parity_err_q;
    logic par_bad_q;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
            par_bad_q    <= 1'b0;
`endif
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            // A load later in this block overrides the clear (simultaneous drain and fill).
            if (valid_q && i_ready) begin
                valid_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (!rx_s) begin
                        state_q <= StStart;
                        cnt_q   <= HALF_LOAD;
                    end
                end

                StStart: begin
                    if (cnt_done) begin
                        if (rx_s) begin
                            state_q <= StIdle;
                        end else begin
                            state_q <= StData;
                            idx_q   <= '0;
                            cnt_q   <= FULL_LOAD;
`ifdef UART_RX_PARITY_EN
                            par_bad_q <= 1'b0;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                StData: begin
                    if (cnt_done) begin
                        shift_q[idx_q] <= rx_s;
                        cnt_q          <= FULL_LOAD;
                        if (idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= StParity;
`else
                            state_q <= StStop;
`endif
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (cnt_done) begin
                        // Even parity: data bits plus parity bit must XOR to zero.
                        if (^{shift_q, rx_s}) begin
                            parity_err_q <= 1'b1;
                            par_bad_q    <= 1'b1;
                        end
                        cnt_q   <= FULL_LOAD;
                        state_q <= StStop;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
`endif

                StStop: begin
                    if (cnt_done) begin
                        if (rx_s) begin
                            state_q <= StIdle;
`ifdef UART_RX_PARITY_EN
                            if (!par_bad_q) begin
`else
                            begin
`endif
                                if (valid_q && !i_ready) begin
                                    overrun_q <= 1'b1;
                                end else begin
                                    data_q  <= shift_q;
                                    valid_q <= 1'b1;
                                end
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= StBreak;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                StBreak: begin
                    // Hold off new starts until the line returns to idle.
                    if (rx_s) begin
                        state_q <= StIdle;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;
    assign o_busy      = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = parity_err_q;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule
